// File: rtl/pwm_multi_pkg.sv
// Shared definitions for the multi-channel PWM controller.
//   MODE_EDGE / MODE_CENTER : values of the CENTER parameter
//   ch_width()              : width of the channel-select field for NCH channels
package pwm_multi_pkg;

    localparam int MODE_EDGE   = 0;
    localparam int MODE_CENTER = 1;

    // Select width is clog2(NCH), but never narrower than one bit so a
    // single-channel build still has a legal port.
    function automatic int ch_width(input int nch);
        return ($clog2(nch) < 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: counter, up/down direction, shadow/active period-duty-enable
// registers, pending flag and output decode.
//   clk, reset          : clock, asynchronous active-high reset
//   kill                : synchronous emergency stop
//   wr                  : shadow load strobe (already address-decoded)
//   period, duty, en    : values written into the shadow registers
//   pwm                 : PWM output
//   cycle_start         : one-clock pulse at each period start
module pwm_channel
    import pwm_multi_pkg::*;
#(
    parameter int CNT_W  = 28,
    parameter int CENTER = MODE_EDGE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             kill,
    input  logic             wr,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    input  logic             en,
    output logic             pwm,
    output logic             cycle_start
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] act_p, act_d, sh_p, sh_d, cnt, cnt_nxt;
    logic             act_en, sh_en, pend, dir_up, dir_nxt, bnd;

    // Next count and boundary detection. A disabled channel or P == 0 is
    // treated as "boundary every clock", which also gives the immediate
    // shadow load a disabled channel needs.
    always_comb begin
        cnt_nxt = '0;
        dir_nxt = 1'b1;
        bnd     = 1'b1;
        if (act_en && (act_p != '0)) begin
            if (CENTER == MODE_CENTER) begin
                if (dir_up && (cnt < act_p)) begin
                    cnt_nxt = cnt + ONE;
                    bnd     = 1'b0;
                end else if (cnt > ONE) begin
                    // Turning at the top, or still descending.
                    cnt_nxt = cnt - ONE;
                    dir_nxt = 1'b0;
                    bnd     = 1'b0;
                end
                // Remaining case: cnt == 1 heading down (or P == 1 at the
                // top), which is the step back to 0 and the period boundary.
            end else begin
                if (cnt < act_p) begin
                    cnt_nxt = cnt + ONE;
                    bnd     = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            dir_up <= 1'b1;
            act_p  <= '0;
            act_d  <= '0;
            act_en <= 1'b0;
            sh_p   <= '0;
            sh_d   <= '0;
            sh_en  <= 1'b0;
            pend   <= 1'b0;
        end else if (kill) begin
            // Period/duty are kept; only enables and sequencing are cleared.
            cnt    <= '0;
            dir_up <= 1'b1;
            act_en <= 1'b0;
            sh_en  <= 1'b0;
            pend   <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            dir_up <= dir_nxt;
            // The boundary consumes the shadow as it stood before this edge;
            // a coincident write lands in the shadow and stays pending.
            if (bnd && pend) begin
                act_p  <= sh_p;
                act_d  <= sh_d;
                act_en <= sh_en;
            end
            if (wr) begin
                sh_p  <= period;
                sh_d  <= duty;
                sh_en <= en;
                pend  <= 1'b1;
            end else if (bnd && pend) begin
                pend  <= 1'b0;
            end
        end
    end

    assign pwm         = act_en && (cnt < act_d) && !kill;
    assign cycle_start = act_en && (cnt == '0) && ((CENTER == MODE_EDGE) || dir_up) && !kill;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM controller: NCH independent channels sharing one
// configuration write port, with edge- or center-aligned counting.
//   clk, reset   : clock, asynchronous active-high reset
//   kill         : synchronous emergency stop for all channels
//   cfg_wr       : write strobe, accepted every cycle it is high
//   cfg_ch       : target channel (values >= NCH are ignored)
//   cfg_period   : period P
//   cfg_duty     : duty D
//   cfg_en       : channel enable
//   pwm          : PWM outputs, bit i is channel i
//   cycle_start  : per-channel period-start pulse
module pwm_multi_ctrl
    import pwm_multi_pkg::*;
#(
    parameter int  NCH    = 4,
    parameter int  CNT_W  = 28,
    parameter int  CENTER = MODE_EDGE,
    localparam int CH_W   = ch_width(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             kill,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    input  logic             cfg_en,
    output logic [NCH-1:0]   pwm,
    output logic [NCH-1:0]   cycle_start
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        // Out-of-range channel numbers never match any index, so they drop.
        logic sel;
        assign sel = cfg_wr && (cfg_ch == CH_W'(i));

        pwm_channel #(
            .CNT_W  (CNT_W),
            .CENTER (CENTER)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .kill        (kill),
            .wr          (sel),
            .period      (cfg_period),
            .duty        (cfg_duty),
            .en          (cfg_en),
            .pwm         (pwm[i]),
            .cycle_start (cycle_start[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Bench for pwm_multi_ctrl: one edge-aligned instance (4 channels) and one
// center-aligned instance (3 channels, so channel 3 is out of range) share the
// same stimulus and are compared every clock against a phase-based model.
module tb_pwm_multi_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       kill = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_period = '0;
    logic [7:0] cfg_duty = '0;
    logic       cfg_en = 1'b0;
    logic [3:0] pwm_e, cs_e;
    logic [2:0] pwm_c, cs_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_multi_ctrl #(.NCH(4), .CNT_W(8), .CENTER(0)) u_edge (
        .clk(clk), .reset(reset), .kill(kill), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_en(cfg_en),
        .pwm(pwm_e), .cycle_start(cs_e)
    );

    pwm_multi_ctrl #(.NCH(3), .CNT_W(8), .CENTER(1)) u_center (
        .clk(clk), .reset(reset), .kill(kill), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_en(cfg_en),
        .pwm(pwm_c), .cycle_start(cs_c)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: each channel tracks its position k within the current period
    // (0 .. len-1); the visible count is derived from k by the mode's shape.
    typedef struct {
        int p, d, sp, sd, k;
        bit en, sen, pend;
    } ch_t;

    ch_t m [2][4];
    int  hi_e [4], st_e [4], hi_c [3], st_c [3];

    function automatic int nch(input int md);
        return (md == 1) ? 3 : 4;
    endfunction

    function automatic int plen(input int md, input int p);
        if (p == 0) return 1;
        return (md == 1) ? 2 * p : p + 1;
    endfunction

    function automatic int mcnt(input int md, input int p, input int k);
        return ((md == 1) && (k > p)) ? 2 * p - k : k;
    endfunction

    function automatic int exp_out(input int md, input bit want_cs);
        int r = 0;
        for (int i = 0; i < nch(md); i++) begin
            bit b;
            if (want_cs) b = m[md][i].en && (m[md][i].k == 0);
            else         b = m[md][i].en && (mcnt(md, m[md][i].p, m[md][i].k) < m[md][i].d);
            if (b && !kill) r |= (1 << i);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int md = 0; md < 2; md++)
            for (int i = 0; i < 4; i++)
                m[md][i] = '{p: 0, d: 0, sp: 0, sd: 0, k: 0, en: 1'b0, sen: 1'b0, pend: 1'b0};
    endtask

    task automatic model_clock();
        for (int md = 0; md < 2; md++) begin
            for (int i = 0; i < nch(md); i++) begin
                bit load;
                if (kill) begin
                    m[md][i].k    = 0;
                    m[md][i].en   = 1'b0;
                    m[md][i].sen  = 1'b0;
                    m[md][i].pend = 1'b0;
                    continue;
                end
                load = 1'b0;
                if (!m[md][i].en) begin
                    m[md][i].k = 0;
                    load = m[md][i].pend;
                end else begin
                    m[md][i].k++;
                    if (m[md][i].k >= plen(md, m[md][i].p)) begin
                        m[md][i].k = 0;
                        load = m[md][i].pend;
                    end
                end
                if (load) begin
                    m[md][i].p    = m[md][i].sp;
                    m[md][i].d    = m[md][i].sd;
                    m[md][i].en   = m[md][i].sen;
                    m[md][i].pend = 1'b0;
                end
                if (cfg_wr && (int'(cfg_ch) == i)) begin
                    m[md][i].sp   = int'(cfg_period);
                    m[md][i].sd   = int'(cfg_duty);
                    m[md][i].sen  = cfg_en;
                    m[md][i].pend = 1'b1;
                end
            end
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 4; i++) begin hi_e[i] = 0; st_e[i] = 0; end
        for (int i = 0; i < 3; i++) begin hi_c[i] = 0; st_c[i] = 0; end
    endtask

    // Inputs are stable from 1 time unit after a rising edge; outputs are
    // checked around the falling edge, then the model advances on the edge.
    task automatic tick();
        #4;
        chk("pwm_edge", int'(pwm_e), exp_out(0, 1'b0));
        chk("cs_edge",  int'(cs_e),  exp_out(0, 1'b1));
        chk("pwm_ctr",  int'(pwm_c), exp_out(1, 1'b0));
        chk("cs_ctr",   int'(cs_c),  exp_out(1, 1'b1));
        for (int i = 0; i < 4; i++) begin hi_e[i] += int'(pwm_e[i]); st_e[i] += int'(cs_e[i]); end
        for (int i = 0; i < 3; i++) begin hi_c[i] += int'(pwm_c[i]); st_c[i] += int'(cs_c[i]); end
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic write(input int ch, input int p, input int d, input bit en);
        cfg_wr     = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_period = 8'(p);
        cfg_duty   = 8'(d);
        cfg_en     = en;
        tick();
        cfg_wr     = 1'b0;
    endtask

    initial begin
        model_reset();
        clear_obs();
        #3;
        chk("rst_pwm_edge", int'(pwm_e), 0);
        chk("rst_cs_edge",  int'(cs_e),  0);
        chk("rst_pwm_ctr",  int'(pwm_c), 0);
        chk("rst_cs_ctr",   int'(cs_c),  0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) tick();

        // Center-aligned P=4 D=2: 8-clock period, 3 high clocks, one start.
        write(1, 4, 2, 1'b1);
        tick();
        clear_obs();
        repeat (8) tick();
        chk("ctr_p4d2_high",   hi_c[1], 3);
        chk("ctr_p4d2_starts", st_c[1], 1);

        // Edge-aligned P=9 D=3: 3 high / 7 low, start every 10 clocks.
        write(0, 9, 3, 1'b1);
        tick();
        clear_obs();
        repeat (20) tick();
        chk("edge_p9d3_high",   hi_e[0], 6);
        chk("edge_p9d3_starts", st_e[0], 2);

        // Duty change at cnt=4 applies from the next period only.
        repeat (4) tick();
        write(0, 9, 7, 1'b1);
        repeat (5) tick();
        clear_obs();
        repeat (10) tick();
        chk("edge_newduty_high", hi_e[0], 7);

        // A write coincident with the wrap waits a whole period.
        repeat (9) tick();
        write(0, 9, 2, 1'b1);
        clear_obs();
        repeat (10) tick();
        chk("edge_wrapwr_old", hi_e[0], 7);
        clear_obs();
        repeat (10) tick();
        chk("edge_wrapwr_new", hi_e[0], 2);

        // D > P is constant high; D == 0 is constant low but still starts.
        write(1, 9, 12, 1'b1);
        write(2, 9, 0, 1'b1);
        repeat (12) tick();
        clear_obs();
        repeat (10) tick();
        chk("edge_dgtp_high",   hi_e[1], 10);
        chk("edge_d0_high",     hi_e[2], 0);
        chk("edge_d0_starts",   st_e[2], 1);

        // Kill pulse with a write attempted during it; everything stays off.
        kill       = 1'b1;
        cfg_wr     = 1'b1;
        cfg_ch     = 2'd0;
        cfg_period = 8'd5;
        cfg_duty   = 8'd3;
        cfg_en     = 1'b1;
        tick();
        kill   = 1'b0;
        cfg_wr = 1'b0;
        clear_obs();
        repeat (15) tick();
        chk("kill_edge_high",   hi_e[0] + hi_e[1] + hi_e[2] + hi_e[3], 0);
        chk("kill_edge_starts", st_e[0] + st_e[1] + st_e[2] + st_e[3], 0);
        chk("kill_ctr_high",    hi_c[0] + hi_c[1] + hi_c[2], 0);

        // Randomised traffic, including out-of-range channel 3 on the
        // center instance and occasional kills.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(3) == 0) begin
                cfg_wr     = 1'b1;
                cfg_ch     = 2'($urandom_range(3));
                cfg_period = 8'($urandom_range(10));
                cfg_duty   = 8'($urandom_range(12));
                cfg_en     = ($urandom_range(4) != 0);
            end
            kill = ($urandom_range(59) == 0);
            tick();
            cfg_wr = 1'b0;
            kill   = 1'b0;
        end

        // Asynchronous reset in the middle of a period.
        write(0, 9, 7, 1'b1);
        write(1, 9, 7, 1'b1);
        repeat (25) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_pwm_edge", int'(pwm_e), 0);
        chk("mid_rst_cs_edge",  int'(cs_e),  0);
        chk("mid_rst_pwm_ctr",  int'(pwm_c), 0);
        chk("mid_rst_cs_ctr",   int'(cs_c),  0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_obs();
        repeat (12) tick();
        chk("post_rst_edge_starts", st_e[0] + st_e[1] + st_e[2] + st_e[3], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
